// File: rtl/pong_lfsr_pkg.sv
// Shared definitions for the LFSR random source and its sequence checker.
package pong_lfsr_pkg;

    typedef enum logic {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } chk_state_t;

    localparam int LFSR_SEED    = 1;
    localparam int ERR_CNT_W    = 16;
    localparam int CNT_W        = 4;
    localparam int DEF_LOCK_CNT = 4;
    localparam int DEF_LOSS_CNT = 3;

    // The error counter sticks at all-ones instead of wrapping back to zero.
    function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] value);
        return (&value) ? value : value + 1'b1;
    endfunction

endpackage

// File: rtl/lfsr_step.sv
// One step of the Fibonacci LFSR: index 1 is the MSB and receives the feedback bit.
module lfsr_step #(
    parameter int N = 3
) (
    input  logic [1:N] din,
    output logic [1:N] nxt
);

    logic taps;

    generate
        if (N == 3) begin : g_n3
            assign taps = din[3] ^ din[2];
        end else if (N == 4) begin : g_n4
            assign taps = din[3] ^ din[4];
        end else begin : g_n5
            assign taps = din[5] ^ din[3];
        end
    endgenerate

    assign nxt = {taps, din[1:N-1]};

endmodule

// File: rtl/lfsr_checker.sv
// Locks onto an incoming LFSR word stream, then flags and counts every word that breaks it.
// Handshake: in_valid qualifies din for one cycle; there is no ready, every valid word is consumed.
module lfsr_checker
    import pong_lfsr_pkg::*;
#(
    parameter int N        = 3,
    parameter int LOCK_CNT = DEF_LOCK_CNT,
    parameter int LOSS_CNT = DEF_LOSS_CNT
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    input  logic [1:N]           din,
    input  logic                 clr_cnt,
    output logic                 locked,
    output logic                 err_pulse,
    output logic [ERR_CNT_W-1:0] err_cnt
);

    localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCK_CNT);
    localparam logic [CNT_W-1:0] LOSS_LAST = CNT_W'(LOSS_CNT);

    chk_state_t           state;
    chk_state_t           state_next;
    logic [1:N]           exp_word;
    logic [1:N]           exp_next;
    logic [1:N]           din_step;
    logic [1:N]           exp_step;
    logic                 have_prev;
    logic                 have_next;
    logic [CNT_W-1:0]     match_cnt;
    logic [CNT_W-1:0]     match_next;
    logic [CNT_W-1:0]     match_inc;
    logic [CNT_W-1:0]     miss_cnt;
    logic [CNT_W-1:0]     miss_next;
    logic [CNT_W-1:0]     miss_inc;
    logic                 din_nz;
    logic                 din_match;
    logic                 err_hit;
    logic [ERR_CNT_W-1:0] err_cnt_next;

    lfsr_step #(.N(N)) u_step_din (
        .din (din),
        .nxt (din_step)
    );

    // Once locked the prediction free-runs off its own history, so a single bad word costs one error.
    lfsr_step #(.N(N)) u_step_exp (
        .din (exp_word),
        .nxt (exp_step)
    );

    assign din_nz    = |din;
    assign din_match = (din == exp_word);
    assign match_inc = match_cnt + 1'b1;
    assign miss_inc  = miss_cnt + 1'b1;

    always_comb begin
        state_next = state;
        exp_next   = exp_word;
        have_next  = have_prev;
        match_next = match_cnt;
        miss_next  = miss_cnt;
        err_hit    = 1'b0;

        if (in_valid) begin
            case (state)
                HUNT: begin
                    if (!have_prev && din_nz) begin
                        exp_next  = din_step;
                        have_next = 1'b1;
                    end else if (din_match && din_nz) begin
                        exp_next = din_step;
                        if (match_inc == LOCK_LAST) begin
                            state_next = LOCKED;
                            match_next = '0;
                            miss_next  = '0;
                        end else begin
                            match_next = match_inc;
                        end
                    end else begin
                        match_next = '0;
                        if (din_nz) begin
                            exp_next = din_step;
                        end else begin
                            have_next = 1'b0;
                        end
                    end
                end

                LOCKED: begin
                    exp_next = exp_step;
                    if (din_match) begin
                        miss_next = '0;
                    end else begin
                        err_hit = 1'b1;
                        if (miss_inc == LOSS_LAST) begin
                            state_next = HUNT;
                            have_next  = 1'b0;
                            match_next = '0;
                            miss_next  = '0;
                        end else begin
                            miss_next = miss_inc;
                        end
                    end
                end

                default: begin
                    state_next = HUNT;
                end
            endcase
        end

        // A clear in the same cycle as an error wins; that error is not counted.
        if (clr_cnt) begin
            err_cnt_next = '0;
        end else if (err_hit) begin
            err_cnt_next = sat_inc(err_cnt);
        end else begin
            err_cnt_next = err_cnt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= HUNT;
            exp_word  <= '0;
            have_prev <= 1'b0;
            match_cnt <= '0;
            miss_cnt  <= '0;
            locked    <= 1'b0;
            err_pulse <= 1'b0;
            err_cnt   <= '0;
        end else begin
            state     <= state_next;
            exp_word  <= exp_next;
            have_prev <= have_next;
            match_cnt <= match_next;
            miss_cnt  <= miss_next;
            locked    <= (state_next == LOCKED);
            err_pulse <= err_hit;
            err_cnt   <= err_cnt_next;
        end
    end

endmodule

// File: tb/tb_lfsr_checker.sv
// Bench for lfsr_checker: three instances (N=4, N=3, N=5 with fast lock / slow loss) checked
// cycle by cycle against a sequence-level model, plus hand-computed directed expectations.
module tb_lfsr_checker;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst;

    logic       v4, v3, v5;
    logic [1:4] d4;
    logic [1:3] d3;
    logic [1:5] d5;
    logic       c4, c3, c5;
    logic       l4, l3, l5;
    logic       p4, p3, p5;
    logic [15:0] e4, e3, e5;

    lfsr_checker #(.N(4), .LOCK_CNT(4), .LOSS_CNT(3)) dut4 (
        .clk(clk), .rst(rst), .in_valid(v4), .din(d4), .clr_cnt(c4),
        .locked(l4), .err_pulse(p4), .err_cnt(e4)
    );
    lfsr_checker #(.N(3), .LOCK_CNT(4), .LOSS_CNT(3)) dut3 (
        .clk(clk), .rst(rst), .in_valid(v3), .din(d3), .clr_cnt(c3),
        .locked(l3), .err_pulse(p3), .err_cnt(e3)
    );
    lfsr_checker #(.N(5), .LOCK_CNT(1), .LOSS_CNT(15)) dut5 (
        .clk(clk), .rst(rst), .in_valid(v5), .din(d5), .clr_cnt(c5),
        .locked(l5), .err_pulse(p5), .err_cnt(e5)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Words are plain integers: S[1] is the most significant of the N bits.
    function automatic int nxt(input int n, input int v);
        int t;
        case (n)
            3:       t = (v & 1) ^ ((v >> 1) & 1);
            4:       t = ((v >> 1) & 1) ^ (v & 1);
            default: t = (v & 1) ^ ((v >> 2) & 1);
        endcase
        return (t << (n - 1)) | (v >> 1);
    endfunction

    typedef struct {
        int lk;
        int have;
        int ev;
        int mc;
        int xc;
        int ep;
        int ec;
    } mdl_t;

    function automatic mdl_t mdl_reset();
        mdl_t r;
        r.lk = 0; r.have = 0; r.ev = 0; r.mc = 0; r.xc = 0; r.ep = 0; r.ec = 0;
        return r;
    endfunction

    function automatic mdl_t mdl_step(input mdl_t m, input int n, input int lock_n,
                                      input int loss_n, input logic vld, input int v,
                                      input logic clr);
        mdl_t r;
        bit   inc;
        r    = m;
        inc  = 1'b0;
        r.ep = 0;
        if (vld) begin
            if (r.lk == 0) begin
                if (r.have == 0 && v != 0) begin
                    r.ev   = nxt(n, v);
                    r.have = 1;
                end else if (v == r.ev && v != 0) begin
                    r.mc++;
                    r.ev = nxt(n, v);
                    if (r.mc == lock_n) begin
                        r.lk = 1; r.mc = 0; r.xc = 0;
                    end
                end else begin
                    r.mc = 0;
                    if (v != 0) r.ev = nxt(n, v);
                    else        r.have = 0;
                end
            end else begin
                if (v == r.ev) begin
                    r.xc = 0;
                end else begin
                    r.ep = 1;
                    inc  = 1'b1;
                    r.xc++;
                    if (r.xc == loss_n) begin
                        r.lk = 0; r.have = 0; r.mc = 0;
                    end
                end
                r.ev = nxt(n, r.ev);
            end
        end
        if (clr) r.ec = 0;
        else if (inc && r.ec < 65535) r.ec++;
        return r;
    endfunction

    // ---------------- scoreboard ----------------
    mdl_t m4, m3, m5;
    logic [17:0] exp_q4[$];
    logic [17:0] exp_q3[$];
    logic [17:0] exp_q5[$];
    logic [17:0] ce;

    always @(posedge clk) begin
        if (rst) begin
            m4 = mdl_reset();
            m3 = mdl_reset();
            m5 = mdl_reset();
        end else begin
            m4 = mdl_step(m4, 4, 4, 3,  v4, int'(d4), c4);
            m3 = mdl_step(m3, 3, 4, 3,  v3, int'(d3), c3);
            m5 = mdl_step(m5, 5, 1, 15, v5, int'(d5), c5);
        end
        exp_q4.push_back({m4.lk[0], m4.ep[0], m4.ec[15:0]});
        exp_q3.push_back({m3.lk[0], m3.ep[0], m3.ec[15:0]});
        exp_q5.push_back({m5.lk[0], m5.ep[0], m5.ec[15:0]});
    end

    always @(negedge clk) begin
        if (exp_q4.size() != 0) begin
            ce = exp_q4.pop_front();
            chk("cyc4_locked", 32'(l4), 32'(ce[17]));
            chk("cyc4_err_pulse", 32'(p4), 32'(ce[16]));
            chk("cyc4_err_cnt", 32'(e4), 32'(ce[15:0]));
        end
        if (exp_q3.size() != 0) begin
            ce = exp_q3.pop_front();
            chk("cyc3_locked", 32'(l3), 32'(ce[17]));
            chk("cyc3_err_pulse", 32'(p3), 32'(ce[16]));
            chk("cyc3_err_cnt", 32'(e3), 32'(ce[15:0]));
        end
        if (exp_q5.size() != 0) begin
            ce = exp_q5.pop_front();
            chk("cyc5_locked", 32'(l5), 32'(ce[17]));
            chk("cyc5_err_pulse", 32'(p5), 32'(ce[16]));
            chk("cyc5_err_cnt", 32'(e5), 32'(ce[15:0]));
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drv4(input logic vld, input logic [3:0] v);
        v4 = vld; d4 = v; step(); v4 = 1'b0;
    endtask

    task automatic drv3(input logic vld, input logic [2:0] v);
        v3 = vld; d3 = v; step(); v3 = 1'b0;
    endtask

    task automatic drv5(input logic vld, input logic [4:0] v);
        v5 = vld; d5 = v; step(); v5 = 1'b0;
    endtask

    // ---------------- directed stimulus ----------------
    int g4, g3, g5;
    logic [3:0] seq4 [5];
    logic [2:0] seq3 [10];
    logic       lk3  [10];

    initial begin
        rst = 1'b1;
        v4 = 0; v3 = 0; v5 = 0;
        d4 = '0; d3 = '0; d5 = '0;
        c4 = 0; c3 = 0; c5 = 0;
        repeat (3) step();
        rst = 1'b0;
        chk("reset_locked", 32'(l4), 32'd0);
        chk("reset_err_pulse", 32'(p4), 32'd0);
        chk("reset_err_cnt", 32'(e4), 32'd0);

        // Reference sequence from seed 0001, hand-derived.
        seq4 = '{4'b0001, 4'b1000, 4'b0100, 4'b0010, 4'b1001};
        for (int i = 0; i < 5; i++) begin
            drv4(1'b1, seq4[i]);
            chk("lock_rise_n4", 32'(l4), 32'(i == 4));
        end
        g4 = 4'b1100;
        for (int i = 0; i < 100; i++) begin
            drv4(1'b1, 4'(g4));
            g4 = nxt(4, g4);
            chk("lock_hold_n4", 32'(l4), 32'd1);
        end
        chk("clean_err_cnt", 32'(e4), 32'd0);

        // Single corrupted word.
        drv4(1'b1, 4'(g4 ^ 8));
        g4 = nxt(4, g4);
        chk("corrupt_pulse", 32'(p4), 32'd1);
        chk("corrupt_cnt", 32'(e4), 32'd1);
        chk("corrupt_locked", 32'(l4), 32'd1);
        drv4(1'b1, 4'(g4));
        g4 = nxt(4, g4);
        chk("after_corrupt_pulse", 32'(p4), 32'd0);
        chk("after_corrupt_cnt", 32'(e4), 32'd1);

        // Clear on an idle cycle, then a stuck word drops lock after three misses.
        c4 = 1'b1; step(); c4 = 1'b0;
        chk("clr_idle", 32'(e4), 32'd0);
        for (int k = 1; k <= 3; k++) begin
            drv4(1'b1, 4'b0101);
            g4 = nxt(4, g4);
            chk("stuck_cnt", 32'(e4), 32'(k));
            chk("stuck_pulse", 32'(p4), 32'd1);
            chk("stuck_locked", 32'(l4), 32'(k < 3));
        end
        for (int i = 0; i < 5; i++) begin
            drv4(1'b1, 4'(g4));
            g4 = nxt(4, g4);
            chk("relock_n4", 32'(l4), 32'(i == 4));
        end
        chk("relock_err_cnt", 32'(e4), 32'd3);

        // N=3: three matches, an all-zero word, then the sequence must start over.
        seq3 = '{3'b001, 3'b100, 3'b010, 3'b101, 3'b000,
                 3'b110, 3'b111, 3'b011, 3'b001, 3'b100};
        lk3  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1};
        for (int i = 0; i < 10; i++) begin
            drv3(1'b1, seq3[i]);
            chk("zero_hunt_n3", 32'(l3), 32'(lk3[i]));
        end
        chk("zero_hunt_err", 32'(e3), 32'd0);
        g3 = 3'b010;

        // Reset while locked, with an error presented in the same cycle.
        rst = 1'b1; v4 = 1'b1; d4 = 4'(g4 ^ 8);
        step();
        rst = 1'b0; v4 = 1'b0;
        g4 = nxt(4, g4);
        chk("rst_mid_locked", 32'(l4), 32'd0);
        chk("rst_mid_pulse", 32'(p4), 32'd0);
        chk("rst_mid_cnt", 32'(e4), 32'd0);
        chk("rst_mid_locked_n3", 32'(l3), 32'd0);
        for (int i = 0; i < 5; i++) begin
            drv4(1'b1, 4'(g4));
            g4 = nxt(4, g4);
            chk("post_rst_lock", 32'(l4), 32'(i == 4));
        end

        // N=3 re-lock with random idle gaps between valid samples.
        for (int i = 0; i < 5; i++) begin
            repeat ($urandom_range(0, 3)) begin
                step();
                chk("gap_idle_locked", 32'(l3), 32'd0);
            end
            drv3(1'b1, 3'(g3));
            g3 = nxt(3, g3);
            chk("gap_lock_n3", 32'(l3), 32'(i == 4));
        end

        // N=5, lock after one match, loss after 15 misses: drive err_cnt into saturation.
        g5 = 1;
        drv5(1'b1, 5'(g5)); g5 = nxt(5, g5);
        drv5(1'b1, 5'(g5)); g5 = nxt(5, g5);
        chk("fast_lock_n5", 32'(l5), 32'd1);
        for (int grp = 0; grp < 4682; grp++) begin
            for (int j = 0; j < 14; j++) begin
                drv5(1'b1, 5'd0);
                g5 = nxt(5, g5);
            end
            drv5(1'b1, 5'(g5));
            g5 = nxt(5, g5);
        end
        chk("sat_reached", 32'(e5), 32'hFFFF);
        chk("sat_locked", 32'(l5), 32'd1);
        for (int j = 0; j < 3; j++) begin
            drv5(1'b1, 5'd0);
            g5 = nxt(5, g5);
            chk("sat_hold", 32'(e5), 32'hFFFF);
            chk("sat_pulse", 32'(p5), 32'd1);
        end
        c5 = 1'b1;
        drv5(1'b1, 5'd0);
        c5 = 1'b0;
        g5 = nxt(5, g5);
        chk("clr_wins_cnt", 32'(e5), 32'd0);
        chk("clr_wins_pulse", 32'(p5), 32'd1);
        drv5(1'b1, 5'd0);
        g5 = nxt(5, g5);
        chk("count_after_clr", 32'(e5), 32'd1);
        drv5(1'b1, 5'(g5));
        g5 = nxt(5, g5);
        chk("match_after_clr_pulse", 32'(p5), 32'd0);
        chk("match_after_clr_locked", 32'(l5), 32'd1);

        step();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/lfsr_checker.md
# lfsr_checker

Receiving end of the on-chip LFSR random source. It takes the N-bit LFSR state word a generator presents each cycle, predicts the next word with the same polynomial, and locks onto the sequence. Once locked, it flags and counts any word that breaks the sequence. It sits beside the random generator for board bring-up and self-test, and drives a status LED and a debug counter.

## Interface
- N, 3: LFSR width. Legal values are 3, 4 and 5.
- LOCK_CNT, 4: consecutive correct predictions required to enter LOCKED. Range 1..15.
- LOSS_CNT, 3: consecutive mispredictions that drop LOCKED back to HUNT. Range 1..15.
- clk  in  1  clock.
- rst  in  1  reset: synchronous, active-high.
- in_valid  in  1  din carries a new sample this cycle.
- din  in  [1:N]  sampled LFSR state word. Index 1 is the MSB and the insertion point.
- clr_cnt  in  1  synchronous clear of err_cnt.
- locked  out  1  registered; high while in LOCKED.
- err_pulse  out  1  registered; one-cycle strobe for each mispredicted sample in LOCKED.
- err_cnt  out  16  registered; saturating count of mispredictions seen in LOCKED.

## Operation
- Step function, on word S: taps is S[3]^S[2] for N=3, S[3]^S[4] for N=4, and S[5]^S[3] for N=5. next(S) = {taps, S[1:N-1]}. Period is 2^N-1. All-zero is never a legal word.
- Internal state:
  - FSM state, one of HUNT or LOCKED.
  - expect[1:N].
  - have_prev flag.
  - match_cnt and miss_cnt, 4 bits each.
- Only cycles with in_valid=1 change FSM state, counters or expect. Cycles with in_valid=0 hold everything.
- HUNT:
  - If have_prev=0 and din is nonzero: expect <= next(din), have_prev <= 1, no compare.
  - Else if din == expect and din is nonzero: match_cnt++ and expect <= next(din). When match_cnt reaches LOCK_CNT, go to LOCKED, clear match_cnt and miss_cnt, and expect <= next(din).
  - Else (mismatch or an all-zero din): match_cnt <= 0. If din is nonzero, expect <= next(din), else have_prev <= 0.
  - err_pulse stays low and err_cnt is unchanged throughout HUNT.
- LOCKED:
  - expect <= next(expect) on every valid sample. The checker free-runs and never reloads from din, so one corrupt word produces exactly one error.
  - Match: miss_cnt <= 0.
  - Mismatch: err_pulse <= 1, err_cnt++ (saturating at 16'hFFFF), miss_cnt++.
  - When miss_cnt reaches LOSS_CNT: go to HUNT with have_prev <= 0 and match_cnt <= 0. The losing sample is still counted as an error.
- clr_cnt has priority over an increment in the same cycle: err_cnt becomes 0 and that error is lost. err_pulse still fires.
- Reset values:
  - FSM in HUNT; have_prev, match_cnt, miss_cnt and expect all 0.
  - Outputs: locked=0, err_pulse=0, err_cnt=0.
  - A reset mid-operation discards lock immediately.

## Timing
- Every output is registered. A sample accepted on clock edge k shows its effect on the outputs after edge k.
- err_pulse is high for exactly the one cycle following the offending valid sample. With back-to-back errors it stays high continuously.
- locked rises in the cycle after the LOCK_CNT-th consecutive match, and falls in the cycle after the LOSS_CNT-th consecutive miss.
- Minimum time to lock is LOCK_CNT+1 valid samples: one load followed by LOCK_CNT matches. Gaps in in_valid stretch this time but never break the lock sequence.
- There is no backpressure. din is sampled only when in_valid=1.

## Structure
- Shared package pong_lfsr_pkg holds:
  - enum chk_state_t {HUNT, LOCKED};
  - constants LFSR_SEED = 1, ERR_CNT_W = 16, and the default LOCK_CNT and LOSS_CNT values.
- Sub-module lfsr_step #(N): combinational, din[1:N] -> next word. Both this checker and the random generator instantiate it, so the two polynomials are identical by construction.

## Test plan
- Reference generator, N=4, seed 4'b0001, in_valid=1 continuously:
  - locked rises after the 5th sample and stays high for 100 cycles.
  - err_pulse never fires and err_cnt stays 0.
- Lock first, then corrupt one word by XORing it with 4'b1000:
  - one err_pulse and err_cnt=1.
  - locked stays high and the next sample matches.
- Lock first, then hold din=4'b0101 for 3 valid samples:
  - errors 1, 2 and 3 are counted; locked falls after the 3rd.
  - restoring the generator re-locks after 5 valid samples.
- All-zero din during HUNT, N=3: match_cnt resets and locked stays 0. Random 0/1 gaps in in_valid during lock-up: locked still rises after exactly 5 valid samples.
- Preload err_cnt to 16'hFFFF with continuous errors: it holds at FFFF. Then assert clr_cnt in the same cycle as an error: err_cnt=0 and err_pulse=1.
- Assert rst mid-LOCKED: next cycle locked=0, err_cnt=0 and err_pulse=0; re-lock follows the normal 5-sample sequence.
